// File: rtl/circle_sprite_raster.sv
// Row-serial circle sprite rasteriser on a valid/ready row stream.
// Define SPRITE_ANNULUS_EN to add inner_radius and punch an annulus hole.
module circle_sprite_raster #(
  parameter  int MAX_RADIUS = 31,
  localparam int RAD_W      = $clog2(MAX_RADIUS + 1),
  localparam int IDX_W      = $clog2(2 * MAX_RADIUS + 1),
  localparam int N          = 2 * MAX_RADIUS + 1
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             start,
  input  logic [RAD_W-1:0] radius,
`ifdef SPRITE_ANNULUS_EN
  input  logic [RAD_W-1:0] inner_radius,
`endif
  output logic             row_valid,
  input  logic             row_ready,
  output logic [IDX_W-1:0] row_idx,
  output logic [N-1:0]     row_bits,
  output logic             busy,
  output logic             frame_done
);
  localparam int SQ_W = 2 * RAD_W + 1;
  localparam logic [RAD_W-1:0] RMAX = RAD_W'(MAX_RADIUS);
  localparam logic [RAD_W-1:0] R1   = RAD_W'(1);
  localparam logic [SQ_W-1:0]  S1   = SQ_W'(1);
  localparam logic [SQ_W-1:0]  CSQ  = SQ_W'(MAX_RADIUS * MAX_RADIUS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] CIDX = IDX_W'(MAX_RADIUS);

  typedef enum logic [2:0] {
    IDLE, LOAD, ROWSET, SEARCH, EMIT
  } state_t;

  state_t state, state_nx;

  logic [RAD_W-1:0] r, ady, w;
  logic [SQ_W-1:0]  r2, dsq, rem, wsq;
  logic [N-1:0]     span, row_nx;
  logic             o_hi, o_lo, o_set;
  logic             settled, last_acc;

  function automatic logic [RAD_W-1:0] clamp(
    input logic [RAD_W-1:0] v
  );
    return (int'(v) > MAX_RADIUS) ? RMAX : v;
  endfunction

  assign o_hi  = wsq >= rem;
  assign o_lo  = (wsq + SQ_W'({w, 1'b1})) < rem;
  assign o_set = !o_hi && !o_lo;

  always_comb begin
    span = '0;
    for (int j = 0; j < N; j++)
      span[j] = (j >= MAX_RADIUS - int'(w)) &&
                (j <= MAX_RADIUS + int'(w));
  end

`ifdef SPRITE_ANNULUS_EN
  logic [RAD_W-1:0] rin, wi;
  logic [SQ_W-1:0]  rin2, remi, wisq;
  logic [N-1:0]     ispan;
  logic             in_act, i_hi, i_lo, i_set;

  assign i_hi  = wisq >= remi;
  assign i_lo  = (wisq + SQ_W'({wi, 1'b1})) < remi;
  assign i_set = !in_act || (!i_hi && !i_lo);

  always_comb begin
    ispan = '0;
    for (int j = 0; j < N; j++)
      ispan[j] = (j >= MAX_RADIUS - int'(wi)) &&
                 (j <= MAX_RADIUS + int'(wi));
  end

  assign settled = o_set && i_set;
  assign row_nx  = span & ~(in_act ? ispan : '0);
`else
  assign settled = o_set;
  assign row_nx  = span;
`endif

  assign row_valid = state == EMIT;
  assign busy      = state != IDLE;
  assign last_acc  = row_valid && row_ready &&
                     row_idx == LAST;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = ROWSET;
      ROWSET:  state_nx = (ady >= r) ? EMIT : SEARCH;
      SEARCH:  if (settled) state_nx = EMIT;
      EMIT:
        if (row_ready)
          state_nx = (row_idx == LAST) ? IDLE : ROWSET;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r          <= '0;
      r2         <= '0;
      ady        <= '0;
      dsq        <= '0;
      rem        <= '0;
      w          <= '0;
      wsq        <= '0;
      row_idx    <= '0;
      row_bits   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_acc;
      unique case (state)
        IDLE:
          if (start) r <= clamp(radius);
        LOAD: begin
          r2      <= SQ_W'(r) * SQ_W'(r);
          dsq     <= CSQ;
          ady     <= RMAX;
          row_idx <= '0;
          w       <= '0;
          wsq     <= '0;
        end
        ROWSET: begin
          rem <= (ady >= r) ? '0 : r2 - dsq;
          if (ady >= r) row_bits <= '0;
        end
        SEARCH: begin
          unique case (1'b1)
            o_hi: begin
              w   <= w - R1;
              wsq <= wsq - SQ_W'({w, 1'b0}) + S1;
            end
            o_lo: begin
              w   <= w + R1;
              wsq <= wsq + SQ_W'({w, 1'b1});
            end
            default: ;
          endcase
          if (settled) row_bits <= row_nx;
        end
        EMIT:
          if (row_ready && row_idx != LAST) begin
            row_idx <= row_idx + IDX_W'(1);
            // dy < 0 shrinks |dy|, dy >= 0 grows it
            if (row_idx < CIDX) begin
              ady <= ady - R1;
              dsq <= dsq - SQ_W'({ady, 1'b0}) + S1;
            end else begin
              ady <= ady + R1;
              dsq <= dsq + SQ_W'({ady, 1'b1});
            end
          end
        default: ;
      endcase
    end
  end

`ifdef SPRITE_ANNULUS_EN
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      rin    <= '0;
      rin2   <= '0;
      remi   <= '0;
      wi     <= '0;
      wisq   <= '0;
      in_act <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (start) rin <= clamp(inner_radius);
        LOAD: begin
          rin2 <= SQ_W'(rin) * SQ_W'(rin);
          wi   <= '0;
          wisq <= '0;
        end
        ROWSET: begin
          in_act <= ady < rin;
          remi   <= (ady < rin) ? rin2 - dsq : '0;
        end
        SEARCH:
          if (in_act) begin
            unique case (1'b1)
              i_hi: begin
                wi   <= wi - R1;
                wisq <= wisq - SQ_W'({wi, 1'b0}) + S1;
              end
              i_lo: begin
                wi   <= wi + R1;
                wisq <= wisq + SQ_W'({wi, 1'b1});
              end
              default: ;
            endcase
          end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_circle_sprite_raster.sv
// Randomised self-checking bench for circle_sprite_raster.
// Rows are compared against a direct dx^2+dy^2 pixel model.
module tb_circle_sprite_raster;
  localparam int MR = 31;
  localparam int N  = 2 * MR + 1;

  logic         clock = 1'b0;
  logic         reset_L;
  logic         start;
  logic [4:0]   radius;
  logic [4:0]   inner_radius;
  logic         row_valid;
  logic         row_ready;
  logic [5:0]   row_idx;
  logic [N-1:0] row_bits;
  logic         busy;
  logic         frame_done;

  int vectors;
  int miscompares;
  logic [N-1:0] got [N];

  always #5 clock = ~clock;

  circle_sprite_raster #(.MAX_RADIUS(MR)) dut (
    .clock        (clock),
    .reset_L      (reset_L),
    .start        (start),
    .radius       (radius),
`ifdef SPRITE_ANNULUS_EN
    .inner_radius (inner_radius),
`endif
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .row_idx      (row_idx),
    .row_bits     (row_bits),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_row(
    input int r, input int rin, input int i);
    logic [N-1:0] m;
    int d;
    m = '0;
    for (int j = 0; j < N; j++) begin
      d = (j - MR) * (j - MR) + (i - MR) * (i - MR);
      m[j] = (d < r * r) && (d >= rin * rin);
    end
    return m;
  endfunction

  function automatic logic [63:0] bits(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int j = lo; j <= hi; j++) m[j] = 1'b1;
    return m;
  endfunction

  task automatic run_frame(input int r, input int rin,
                           input int stall_pct, input int hold_row,
                           input bit perturb, input int abort_row);
    int rows, cyc, held, first;
    bit pv, pacc, fin;
    logic [5:0] pidx;
    logic [N-1:0] pbits;
    for (int k = 0; k < N; k++) got[k] = '1;
    @(posedge clock); #1;
    start = 1'b1;
    radius = 5'(r);
    inner_radius = 5'(rin);
    @(posedge clock); #1;
    start = 1'b0;
    rows = 0; cyc = 0; held = 0; first = -1;
    pv = 0; pacc = 0; fin = 0;
    pidx = '0; pbits = '0;
    chk("busy_load", 64'(busy), 64'(1));
    while (!fin) begin
      if (pv && !pacc) begin
        chk("hold_valid", 64'(row_valid), 64'(1));
        chk("hold_idx", 64'(row_idx), 64'(pidx));
        chk("hold_bits", 64'(row_bits), 64'(pbits));
      end
      if (row_valid && first < 0) first = cyc;
      if (frame_done) begin
        fin = 1;
      end else if (abort_row >= 0 && row_valid &&
                   rows == abort_row) begin
        #2 reset_L = 1'b0;
        #1;
        chk("rst_valid", 64'(row_valid), 64'(0));
        chk("rst_idx", 64'(row_idx), 64'(0));
        chk("rst_bits", 64'(row_bits), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(frame_done), 64'(0));
        @(posedge clock); #1;
        chk("rst_idle", 64'(busy), 64'(0));
        reset_L = 1'b1;
        row_ready = 1'b0;
        return;
      end else begin
        row_ready = ($urandom_range(99) >= 32'(stall_pct));
        if (row_valid && rows == hold_row && held < 5) begin
          row_ready = 1'b0;
          held++;
        end
        if (perturb && rows == 30) begin
          start = 1'b1;
          radius = 5'($urandom);
          inner_radius = 5'($urandom);
        end else begin
          start = 1'b0;
        end
        pv = row_valid;
        pacc = row_valid && row_ready;
        pidx = row_idx;
        pbits = row_bits;
        if (pacc) begin
          chk("row_idx", 64'(row_idx), 64'(rows));
          chk("row_bits", 64'(row_bits),
              64'(model_row(r, rin, rows)));
          if (rows < N) got[rows] = row_bits;
          rows++;
        end
        @(posedge clock); #1;
        cyc++;
        if (cyc > 20000) begin
          chk("timeout", 64'(0), 64'(1));
          fin = 1;
        end
      end
    end
    start = 1'b0;
    row_ready = 1'b0;
    chk("row_count", 64'(rows), 64'(N));
    chk("first_lat", 64'(first >= 0 && first <= 2), 64'(1));
    if (hold_row >= 0) chk("held_5", 64'(held), 64'(5));
    @(posedge clock); #1;
    chk("done_once", 64'(frame_done), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_valid", 64'(row_valid), 64'(0));
  endtask

  initial begin
    int rr, ri;
    vectors = 0;
    miscompares = 0;
    reset_L = 1'b0;
    start = 1'b0;
    radius = '0;
    inner_radius = '0;
    row_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_valid", 64'(row_valid), 64'(0));
    chk("reset_idx", 64'(row_idx), 64'(0));
    chk("reset_bits", 64'(row_bits), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(frame_done), 64'(0));
    reset_L = 1'b1;

    run_frame(31, 0, 0, -1, 0, -1);
    chk("r31_row0", 64'(got[0]), 64'(0));
    chk("r31_row31", 64'(got[31]), bits(1, 61));
    chk("r31_row62", 64'(got[62]), 64'(0));

    run_frame(5, 0, 0, -1, 0, -1);
    chk("r5_row28", 64'(got[28]), bits(28, 34));
    chk("r5_row26", 64'(got[26]), 64'(0));
    chk("r5_row36", 64'(got[36]), 64'(0));

    run_frame(1, 0, 0, -1, 0, -1);
    chk("r1_row31", 64'(got[31]), bits(31, 31));
    chk("r1_row30", 64'(got[30]), 64'(0));

    run_frame(0, 0, 0, -1, 0, -1);
    chk("r0_row31", 64'(got[31]), 64'(0));

    run_frame(20, 0, 0, 10, 0, -1);
    run_frame(17, 0, 0, -1, 1, -1);
    run_frame(25, 0, 0, -1, 0, 20);
    run_frame(25, 0, 0, -1, 0, -1);

`ifdef SPRITE_ANNULUS_EN
    run_frame(10, 4, 0, -1, 0, -1);
    chk("ann_row31", 64'(got[31]),
        bits(22, 27) | bits(35, 40));
    run_frame(8, 12, 0, -1, 0, -1);
    chk("ann_big_rin", 64'(got[31]), 64'(0));
`endif

    for (int k = 0; k < 6; k++) begin
      rr = int'($urandom_range(31));
`ifdef SPRITE_ANNULUS_EN
      ri = int'($urandom_range(31));
`else
      ri = 0;
`endif
      run_frame(rr, ri, 30, -1, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
